// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN           - architectural register / address width
//   DefaultResetPc - PC loaded on reset and on a full flush
//   fetch_state_e  - fetch FSM state encoding
//   fetch_entry_t  - one instruction buffer entry {pc, inst}
//   align_pc()     - forces a PC to word alignment
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DefaultResetPc = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDrain
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, inst} pairs for decode.
//   clk_i        - clock, rising edge
//   rst_i        - synchronous active-high reset
//   clear_i      - discard all entries (wins over a same-cycle push)
//   push_i       - write {push_pc_i, push_inst_i}
//   pop_i        - consume the head entry
//   head_valid_o - buffer non-empty
//   head_pc_o    - PC of head entry (0 when empty)
//   head_inst_o  - instruction of head entry (0 when empty)
//   count_o      - number of valid entries
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [XLEN-1:0] push_inst_i,
    input  logic            pop_i,
    output logic            head_valid_o,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_inst_o,
    output logic [CntW-1:0] count_o
);

    fetch_entry_t    mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    // A push into a full buffer is fine when the head leaves on the same edge.
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Depth is a power of two, so pointers wrap by overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && !clear_i && do_push) begin
            mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
        end
    end

    assign head_valid_o = (count_q != '0);
    assign head_pc_o    = head_valid_o ? mem_q[rd_ptr_q].pc   : '0;
    assign head_inst_o  = head_valid_o ? mem_q[rd_ptr_q].inst : '0;
    assign count_o      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, single-outstanding imem requests,
// buffering of returned instructions for decode, and flush/redirect handling.
//   clk_i, rst_i          - clock and synchronous active-high reset
//   begin_execution_i     - fetch enable
//   pc_override_i         - redirect to redirect_pc_i, discard buffered/in-flight
//   redirect_pc_i         - redirect target (low two bits ignored)
//   flush_partial_i       - discard buffered/in-flight, PC held
//   flush_full_i          - discard everything, PC <= RESET_PC
//   imem_req_valid_o/ready_i/addr_o - instruction memory request channel
//   imem_rsp_valid_i/data_i         - instruction memory response (no backpressure)
//   inst_valid_o/ready_i/data_o/pc_o - buffer head to decode
//   fetch_ready_o         - nothing in flight and no stale response pending
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DefaultResetPc,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            begin_execution_i,
    input  logic            pc_override_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            flush_partial_i,
    input  logic            flush_full_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [XLEN-1:0] imem_rsp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            fetch_ready_o
);

    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OccW = CntW + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            outstanding_q, outstanding_d;
    logic            req_valid_q;
    logic            fetch_ready_q;

    logic [CntW-1:0] count;
    logic            head_valid;
    logic            push;
    logic            pop;
    logic            flush_any;
    logic            issue_now;
    logic            issue_after_push;

    assign flush_any = flush_full_i || pc_override_i || flush_partial_i;
    assign pop       = head_valid && inst_ready_i;

    assign issue_now = begin_execution_i &&
        ((OccW'(count) + OccW'(outstanding_q)) < OccW'(BUF_DEPTH));
    // Occupancy once this cycle's response is pushed (and head possibly popped).
    assign issue_after_push = begin_execution_i &&
        ((OccW'(count) + OccW'(1) - OccW'(pop)) < OccW'(BUF_DEPTH));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        push          = 1'b0;

        case (state_q)
            StIdle: begin
                if (issue_now) state_d = StReq;
            end
            StReq: begin
                if (imem_req_ready_i) begin
                    outstanding_d = 1'b1;
                    req_pc_d      = pc_q;
                    pc_d          = pc_q + XLEN'(4);
                    state_d       = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid_i) begin
                    push          = 1'b1;
                    outstanding_d = 1'b0;
                    state_d       = issue_after_push ? StReq : StIdle;
                end
            end
            StDrain: begin
                if (imem_rsp_valid_i) begin
                    outstanding_d = 1'b0;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush_any) begin
            push = 1'b0;
            case (state_q)
                // A handshake completing alongside the flush still owes a response.
                StReq:   state_d = imem_req_ready_i ? StDrain : StIdle;
                StWait:  state_d = imem_rsp_valid_i ? StIdle : StDrain;
                StDrain: state_d = imem_rsp_valid_i ? StIdle : StDrain;
                default: state_d = StIdle;
            endcase
            if (flush_full_i) begin
                pc_d = RESET_PC;
            end else if (pc_override_i) begin
                pc_d = align_pc(redirect_pc_i);
            end else begin
                // Dropped request is refetched from the same PC.
                pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            req_valid_q   <= 1'b0;
            fetch_ready_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            req_valid_q   <= (state_d == StReq);
            fetch_ready_q <= (state_d != StWait) && (state_d != StDrain);
        end
    end

    fetch_buffer #(
        .Depth (BUF_DEPTH)
    ) u_buffer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (flush_any),
        .push_i       (push),
        .push_pc_i    (req_pc_q),
        .push_inst_i  (imem_rsp_data_i),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_pc_o    (inst_pc_o),
        .head_inst_o  (inst_data_o),
        .count_o      (count)
    );

    assign imem_req_valid_o = req_valid_q;
    assign imem_req_addr_o  = pc_q;
    assign inst_valid_o     = head_valid;
    assign fetch_ready_o    = fetch_ready_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        begin_execution;
    logic        pc_override;
    logic [31:0] redirect_pc;
    logic        flush_partial;
    logic        flush_full;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        fetch_ready;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .begin_execution_i (begin_execution),
        .pc_override_i     (pc_override),
        .redirect_pc_i     (redirect_pc),
        .flush_partial_i   (flush_partial),
        .flush_full_i      (flush_full),
        .imem_req_valid_o  (imem_req_valid),
        .imem_req_ready_i  (imem_req_ready),
        .imem_req_addr_o   (imem_req_addr),
        .imem_rsp_valid_i  (imem_rsp_valid),
        .imem_rsp_data_i   (imem_rsp_data),
        .inst_valid_o      (inst_valid),
        .inst_ready_i      (inst_ready),
        .inst_data_o       (inst_data),
        .inst_pc_o         (inst_pc),
        .fetch_ready_o     (fetch_ready)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; return at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        begin_execution = 1'b0;
        pc_override     = 1'b0;
        redirect_pc     = '0;
        flush_partial   = 1'b0;
        flush_full      = 1'b0;
        imem_req_ready  = 1'b0;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        inst_ready      = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_req_valid"},   32'(imem_req_valid), 32'd0);
        check_val({pfx, "_req_addr"},    imem_req_addr,       32'h0000_0000);
        check_val({pfx, "_inst_valid"},  32'(inst_valid),     32'd0);
        check_val({pfx, "_inst_data"},   inst_data,           32'd0);
        check_val({pfx, "_inst_pc"},     inst_pc,             32'd0);
        check_val({pfx, "_fetch_ready"}, 32'(fetch_ready),    32'd1);
    endtask

    // Request is valid at entry: accept it, answer the next cycle, return after the push.
    task automatic serve(input logic [31:0] data);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_reset_outputs("rst");

        // Streaming fetch with an always-ready decode.
        begin_execution = 1'b1;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("seq%0d_req_valid", i), 32'(imem_req_valid), 32'd1);
            check_val($sformatf("seq%0d_req_addr", i), imem_req_addr, 32'(i * 4));
            step();
            check_val($sformatf("seq%0d_wait_ready", i), 32'(fetch_ready), 32'd0);
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hA000_0000 + 32'(i);
            step();
            imem_rsp_valid = 1'b0;
            check_val($sformatf("seq%0d_inst_valid", i), 32'(inst_valid), 32'd1);
            check_val($sformatf("seq%0d_inst_pc", i), inst_pc, 32'(i * 4));
            check_val($sformatf("seq%0d_inst_data", i), inst_data, 32'hA000_0000 + 32'(i));
        end

        // Decode stalled: buffer of two fills, fetch stops.
        do_reset();
        begin_execution = 1'b1;
        imem_req_ready  = 1'b1;
        step();
        check_val("full_req0_addr", imem_req_addr, 32'h0);
        serve(32'h1111_0000);
        check_val("full_req1_valid", 32'(imem_req_valid), 32'd1);
        check_val("full_req1_addr", imem_req_addr, 32'h4);
        serve(32'h1111_0004);
        check_val("full_idle_valid", 32'(imem_req_valid), 32'd0);
        check_val("full_head_pc", inst_pc, 32'h0);
        step();
        step();
        step();
        check_val("full_still_idle", 32'(imem_req_valid), 32'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_val("full_pop_head_pc", inst_pc, 32'h4);
        check_val("full_pop_head_data", inst_data, 32'h1111_0004);
        step();
        check_val("full_refill_valid", 32'(imem_req_valid), 32'd1);
        check_val("full_refill_addr", imem_req_addr, 32'h8);
        serve(32'h1111_0008);
        check_val("full_again_idle", 32'(imem_req_valid), 32'd0);

        // Redirect while a response is in flight.
        do_reset();
        begin_execution = 1'b1;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b1;
        step();
        step();
        check_val("redir_wait_ready", 32'(fetch_ready), 32'd0);
        pc_override = 1'b1;
        redirect_pc = 32'h0000_1003;
        step();
        pc_override = 1'b0;
        check_val("redir_drain_ready", 32'(fetch_ready), 32'd0);
        check_val("redir_drain_valid", 32'(imem_req_valid), 32'd0);
        step();
        check_val("redir_drain_hold", 32'(fetch_ready), 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check_val("redir_drained_ready", 32'(fetch_ready), 32'd1);
        check_val("redir_stale_dropped", 32'(inst_valid), 32'd0);
        step();
        check_val("redir_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("redir_req_addr", imem_req_addr, 32'h0000_1000);
        check_val("redir_buf_empty", 32'(inst_valid), 32'd0);
        serve(32'h0000_CAFE);
        check_val("redir_inst_pc", inst_pc, 32'h0000_1000);
        check_val("redir_inst_data", inst_data, 32'h0000_CAFE);
        check_val("redir_next_addr", imem_req_addr, 32'h0000_1004);

        // flush_full beats pc_override in the same cycle.
        imem_req_ready = 1'b0;
        flush_full     = 1'b1;
        pc_override    = 1'b1;
        redirect_pc    = 32'h0000_2000;
        step();
        flush_full  = 1'b0;
        pc_override = 1'b0;
        check_val("ff_inst_valid", 32'(inst_valid), 32'd0);
        check_val("ff_req_dropped", 32'(imem_req_valid), 32'd0);
        check_val("ff_fetch_ready", 32'(fetch_ready), 32'd1);
        step();
        check_val("ff_req_valid", 32'(imem_req_valid), 32'd1);
        check_val("ff_req_addr", imem_req_addr, 32'h0000_0000);

        // Request held under backpressure, then dropped by a partial flush.
        for (int i = 0; i < 5; i++) begin
            step();
            check_val($sformatf("bp%0d_valid", i), 32'(imem_req_valid), 32'd1);
            check_val($sformatf("bp%0d_addr", i), imem_req_addr, 32'h0000_0000);
        end
        flush_partial = 1'b1;
        step();
        flush_partial = 1'b0;
        check_val("fp_req_valid", 32'(imem_req_valid), 32'd0);
        check_val("fp_fetch_ready", 32'(fetch_ready), 32'd1);
        step();
        check_val("fp_reissue_addr", imem_req_addr, 32'h0000_0000);

        // PC wraps at the top of the address space.
        pc_override = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        pc_override = 1'b0;
        step();
        check_val("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        serve(32'h1234_5678);
        check_val("wrap_next_valid", 32'(imem_req_valid), 32'd1);
        check_val("wrap_next_addr", imem_req_addr, 32'h0000_0000);
        check_val("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);

        // Reset while waiting; the late response must be ignored.
        step();
        check_val("rstw_in_wait", 32'(fetch_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("rstw");
        begin_execution = 1'b0;
        imem_rsp_valid  = 1'b1;
        imem_rsp_data   = 32'h5555_AAAA;
        step();
        imem_rsp_valid = 1'b0;
        check_val("rstw_late_inst_valid", 32'(inst_valid), 32'd0);
        check_val("rstw_late_fetch_ready", 32'(fetch_ready), 32'd1);
        check_val("rstw_late_req_valid", 32'(imem_req_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly downstream of the core controller FSM. Consumes `begin_execution`, `pc_override`, `flush_partial` and `flush_full`; generates the PC and issues single-outstanding requests to instruction memory. Buffers returned instructions in a small FIFO for decode. Reports `fetch_ready` back to the controller once a flush has fully drained.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset and on `flush_full`.
- `BUF_DEPTH`, 2, instruction buffer entries (power of two, ≥2).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `begin_execution` in 1: fetch enable from controller.
- `pc_override` in 1: load PC from `redirect_pc`, discard buffered/in-flight instructions.
- `redirect_pc` in 32: target PC, sampled when `pc_override`=1.
- `flush_partial` in 1: discard buffered/in-flight instructions, PC held.
- `flush_full` in 1: discard everything, PC←`RESET_PC`.
- `imem_req_valid` out 1: request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: request address (current PC).
- `imem_rsp_valid` in 1: response valid (no backpressure).
- `imem_rsp_data` in 32: instruction word.
- `inst_valid` out 1: buffer head valid to decode.
- `inst_ready` in 1: decode consumes head.
- `inst_data` out 32: head instruction.
- `inst_pc` out 32: head PC.
- `fetch_ready` out 1: no request in flight and no stale response pending.

## Operation
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: `imem_req_valid`=0. → REQ when `begin_execution`=1 and `entries + outstanding < BUF_DEPTH`.
- REQ: `imem_req_valid`=1, `imem_req_addr`=PC. On `imem_req_ready`: outstanding←1, record req PC, PC←PC+4, → WAIT.
- WAIT: on `imem_rsp_valid`, push {req PC, data}, outstanding←0. Next state is REQ if the issue condition holds after the push, else IDLE.
- DRAIN: entered on any flush/redirect while outstanding=1. The next `imem_rsp_valid` is dropped, then → IDLE.
- Flush priority, same cycle: `flush_full` > `pc_override` > `flush_partial`. Each clears the buffer. The PC effect of `flush_full` and `pc_override` applies that edge. Any of them in REQ drops the request (see Timing); in WAIT → DRAIN.
- A flush arriving in the same cycle as `imem_rsp_valid` in WAIT: the response is dropped and the next state is IDLE, not DRAIN.
- `fetch_ready` = (state≠WAIT && state≠DRAIN).
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] of `redirect_pc` are forced to 0.
- Buffer push and pop in the same cycle is allowed, including when full, provided the pop is a head pop.
- `begin_execution` dropping to 0 stops new issues only. An in-flight request completes normally.

## Timing
- Reset values: `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fetch_ready`=1, state IDLE, buffer empty.
- `rst` mid-operation overrides all inputs. Any in-flight response arriving after reset is ignored, because outstanding=0 in IDLE.
- `imem_req_addr` and `imem_req_valid` are registered. Both hold stable while valid && !ready, except on a flush, which deasserts valid next cycle.
- Latency: request issue (REQ entered) is 1 cycle after `begin_execution` rises. A response in cycle R gives `inst_valid`=1 in cycle R+1.
- Peak throughput: 1 instruction per 2 cycles (single outstanding).
- Flush asserted in cycle F: `inst_valid`=0 from F+1. If nothing was in flight, `fetch_ready`=1 in F+1.

## Structure
- Shared package `riscv_pkg`: `XLEN`=32, fetch state enum, default `RESET_PC`.
- Sub-module `fetch_buffer`: synchronous FIFO of {pc, inst}, width 64, depth `BUF_DEPTH`. It provides `count`, a clear input, and a registered head.

## Test plan
- Reset, then `begin_execution`=1 with `imem_req_ready`=1 and rsp one cycle after accept → addrs 0x0, 0x4, 0x8 issued; `inst_pc` sequence matches; `inst_data` echoes rsp.
- `inst_ready`=0 with `BUF_DEPTH`=2 → exactly 2 requests issued then IDLE, `imem_req_valid`=0. Pop one → one new request to 0x8.
- `pc_override`=1, `redirect_pc`=0x1003 while in WAIT → `fetch_ready`=0 until the stale rsp is dropped. Next request addr=0x1000, buffer empty.
- `flush_full` and `pc_override` in the same cycle → next addr=`RESET_PC`.
- `imem_req_ready` held 0 for 5 cycles → addr and valid stable. `flush_partial` in REQ → valid=0 next cycle, `fetch_ready`=1.
- PC=0xFFFF_FFFC → next request 0x0. `rst` asserted in WAIT → all outputs at reset values next cycle, late rsp not pushed.
